// File: rtl/tmds_enc_nch.sv
// N-lane TMDS encoder (DVI video/control plus HDMI guard bands and TERC4), with per-lane running disparity.
// Latency 2 clocks from input to tmds. The pipeline never stalls and applies no backpressure.
module tmds_enc_nch #(
    parameter int CHANNELS = 3,
    parameter bit HDMI_EN  = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0]             mode,
    input  logic [8*CHANNELS-1:0]  data,
    input  logic [2*CHANNELS-1:0]  ctrl,
    input  logic [4*CHANNELS-1:0]  aux,
    output logic [10*CHANNELS-1:0] tmds,
    output logic [5*CHANNELS-1:0]  disp
);

    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    function automatic logic [9:0] terc4(input logic [3:0] nib);
        logic [9:0] code;
        case (nib)
            4'd0:    code = 10'b1010011100;
            4'd1:    code = 10'b1001100011;
            4'd2:    code = 10'b1011100100;
            4'd3:    code = 10'b1011100010;
            4'd4:    code = 10'b0101110001;
            4'd5:    code = 10'b0100011110;
            4'd6:    code = 10'b0110001110;
            4'd7:    code = 10'b0100111100;
            4'd8:    code = 10'b1011001100;
            4'd9:    code = 10'b0100111001;
            4'd10:   code = 10'b0110011100;
            4'd11:   code = 10'b1011000110;
            4'd12:   code = 10'b1010001110;
            4'd13:   code = 10'b1001110001;
            4'd14:   code = 10'b0101100011;
            default: code = 10'b1011000011;
        endcase
        return code;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] code;
        case (c)
            2'b00:   code = 10'b1101010100;
            2'b01:   code = 10'b0010101011;
            2'b10:   code = 10'b0101010100;
            default: code = 10'b1010101011;
        endcase
        return code;
    endfunction

    // Stage 1: input registers. s1_vld stays low for the cycle after reset so
    // that exactly two zero symbols follow a reset.
    logic                  s1_vld;
    logic [2:0]            s1_mode;
    logic [8*CHANNELS-1:0] s1_data;
    logic [2*CHANNELS-1:0] s1_ctrl;
    logic [4*CHANNELS-1:0] s1_aux;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_mode <= 3'd0;
            s1_data <= '0;
            s1_ctrl <= '0;
            s1_aux  <= '0;
        end else begin
            s1_vld  <= 1'b1;
            s1_mode <= mode;
            s1_data <= data;
            s1_ctrl <= ctrl;
            s1_aux  <= aux;
        end
    end

    logic [2:0] eff_mode;

    always_comb begin
        eff_mode = s1_mode;
        if (s1_mode > 3'd4) begin
            eff_mode = 3'd0;
        end else if (!HDMI_EN && (s1_mode >= 3'd2)) begin
            eff_mode = 3'd0;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        localparam bit LANE_MID  = ((i % 3) == 1);
        localparam bit LANE_HEAD = ((i % 3) == 0);

        logic [7:0] d;
        logic [1:0] c;
        logic [3:0] a;
        logic [3:0] n1_d;
        logic [3:0] n1_q;
        logic       use_xnor;
        logic       prev;
        logic [7:0] q_m;
        logic       qm8;
        logic [4:0] bal;
        logic       cnt_pos;
        logic       cnt_neg;
        logic       bal_pos;
        logic       bal_neg;
        logic [9:0] vid_sym;
        logic [4:0] vid_cnt;
        logic [9:0] sym_nxt;
        logic [4:0] cnt_nxt;
        logic [9:0] sym_r;
        logic [4:0] cnt_r;

        assign d = s1_data[8*i +: 8];
        assign c = s1_ctrl[2*i +: 2];
        assign a = s1_aux[4*i +: 4];

        // Disparity arithmetic is 5-bit modular; bal = n1 - n0 = 2*n1 - 8.
        always_comb begin
            n1_d = 4'd0;
            for (int b = 0; b < 8; b++) begin
                n1_d = n1_d + {3'b000, d[b]};
            end
            use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
            prev     = d[0];
            q_m      = 8'd0;
            q_m[0]   = d[0];
            for (int b = 1; b < 8; b++) begin
                prev   = use_xnor ? ~(prev ^ d[b]) : (prev ^ d[b]);
                q_m[b] = prev;
            end
            qm8  = !use_xnor;
            n1_q = 4'd0;
            for (int b = 0; b < 8; b++) begin
                n1_q = n1_q + {3'b000, q_m[b]};
            end
            bal     = {n1_q, 1'b0} - 5'd8;
            cnt_pos = !cnt_r[4] && (cnt_r != 5'd0);
            cnt_neg = cnt_r[4];
            bal_pos = !bal[4] && (bal != 5'd0);
            bal_neg = bal[4];

            if ((cnt_r == 5'd0) || (bal == 5'd0)) begin
                vid_sym = {~qm8, qm8, (qm8 ? q_m : ~q_m)};
                vid_cnt = qm8 ? (cnt_r + bal) : (cnt_r - bal);
            end else if ((cnt_pos && bal_pos) || (cnt_neg && bal_neg)) begin
                vid_sym = {1'b1, qm8, ~q_m};
                vid_cnt = cnt_r + {3'b000, qm8, 1'b0} - bal;
            end else begin
                vid_sym = {1'b0, qm8, q_m};
                vid_cnt = cnt_r - {3'b000, ~qm8, 1'b0} + bal;
            end

            sym_nxt = ctrl_code(c);
            cnt_nxt = 5'd0;
            case (eff_mode)
                3'd1: begin
                    sym_nxt = vid_sym;
                    cnt_nxt = vid_cnt;
                end
                3'd2:    sym_nxt = LANE_MID ? GUARD_B : GUARD_A;
                3'd3:    sym_nxt = LANE_HEAD ? terc4(a) : GUARD_B;
                3'd4:    sym_nxt = terc4(a);
                default: sym_nxt = ctrl_code(c);
            endcase
        end

        always_ff @(posedge clock) begin
            if (reset || !s1_vld) begin
                sym_r <= 10'd0;
                cnt_r <= 5'd0;
            end else begin
                sym_r <= sym_nxt;
                cnt_r <= cnt_nxt;
            end
        end

        assign tmds[10*i +: 10] = sym_r;
        assign disp[5*i +: 5]   = cnt_r;
    end

endmodule

// File: tb/tb_tmds_enc_nch.sv
// Scoreboard bench for tmds_enc_nch: an HDMI and a DVI-only instance share stimulus,
// expected symbols come from a table/arithmetic reference model keyed by output cycle.
module tb_tmds_enc_nch;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  mode;
    logic [23:0] data;
    logic [5:0]  ctrl;
    logic [11:0] aux;
    logic [29:0] tmds_h;
    logic [14:0] disp_h;
    logic [29:0] tmds_d;
    logic [14:0] disp_d;

    tmds_enc_nch #(.CHANNELS(3), .HDMI_EN(1'b1)) u_hdmi (
        .clock(clock), .reset(reset), .mode(mode), .data(data),
        .ctrl(ctrl), .aux(aux), .tmds(tmds_h), .disp(disp_h)
    );

    tmds_enc_nch #(.CHANNELS(3), .HDMI_EN(1'b0)) u_dvi (
        .clock(clock), .reset(reset), .mode(mode), .data(data),
        .ctrl(ctrl), .aux(aux), .tmds(tmds_d), .disp(disp_d)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [29:0] th;
        logic [29:0] td;
        logic [14:0] dp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cnt_m[3];

    logic [9:0] terc_tbl [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    logic [9:0] ctrl_tbl [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    function automatic logic [9:0] ref_sym(input int lane, input logic [2:0] md, input bit hdmi,
                                           input logic [7:0] d, input logic [1:0] c,
                                           input logic [3:0] a, input int cnt_in,
                                           output int cnt_out);
        int         m;
        int         n1;
        int         ones;
        int         zeros;
        bit         xn;
        bit         qm8;
        bit         q9;
        logic [7:0] qm;
        logic [7:0] low;
        logic [9:0] r;
        m = int'(md);
        if (m > 4) m = 0;
        if (!hdmi && m >= 2) m = 0;
        cnt_out = 0;
        r = ctrl_tbl[c];
        if (m == 2) begin
            r = (lane % 3 == 1) ? 10'b0100110011 : 10'b1011001100;
        end else if (m == 3) begin
            r = (lane % 3 == 0) ? terc_tbl[a] : 10'b0100110011;
        end else if (m == 4) begin
            r = terc_tbl[a];
        end else if (m == 1) begin
            n1 = $countones(d);
            xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qm[0] = d[0];
            for (int b = 1; b < 8; b++) qm[b] = xn ? ~(qm[b-1] ^ d[b]) : (qm[b-1] ^ d[b]);
            qm8   = !xn;
            ones  = $countones(qm);
            zeros = 8 - ones;
            if (cnt_in == 0 || ones == zeros) begin
                q9      = !qm8;
                low     = qm8 ? qm : ~qm;
                cnt_out = cnt_in + (qm8 ? ones - zeros : zeros - ones);
            end else if ((cnt_in > 0 && ones > zeros) || (cnt_in < 0 && zeros > ones)) begin
                q9      = 1'b1;
                low     = ~qm;
                cnt_out = cnt_in + 2 * int'(qm8) + zeros - ones;
            end else begin
                q9      = 1'b0;
                low     = qm;
                cnt_out = cnt_in - 2 * int'(!qm8) + ones - zeros;
            end
            r = {q9, qm8, low};
        end
        return r;
    endfunction

    task automatic set_exp(input exp_t e);
        bit found = 1'b0;
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (!found && sb[j].due == e.due) begin
                sb[j] = e;
                found = 1'b1;
            end
        end
        if (!found) sb.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic [2:0] md, input logic [23:0] d,
                         input logic [5:0] c, input logic [11:0] a);
        exp_t e;
        int   ch;
        int   cd;
        reset = rst;
        mode  = md;
        data  = d;
        ctrl  = c;
        aux   = a;
        if (rst) begin
            e.th = '0;
            e.td = '0;
            e.dp = '0;
            e.due = cyc + 1;
            set_exp(e);
            e.due = cyc + 2;
            set_exp(e);
            for (int l = 0; l < 3; l++) cnt_m[l] = 0;
        end else begin
            e.due = cyc + 2;
            for (int l = 0; l < 3; l++) begin
                e.th[10*l +: 10] = ref_sym(l, md, 1'b1, d[8*l +: 8], c[2*l +: 2], a[4*l +: 4], cnt_m[l], ch);
                e.td[10*l +: 10] = ref_sym(l, md, 1'b0, d[8*l +: 8], c[2*l +: 2], a[4*l +: 4], cnt_m[l], cd);
                if (ch < -16 || ch > 16) begin
                    checks++;
                    failures++;
                    $display("FAIL cnt_range lane=%0d model_cnt=%0d allowed=-16..16", l, ch);
                end
                e.dp[5*l +: 5] = ch[4:0];
                cnt_m[l] = ch;
            end
            set_exp(e);
        end
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string name, input logic [29:0] got, input logic [29:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                if (sb[0].due == cyc) begin
                    e = sb.pop_front();
                    chk("tmds_hdmi", tmds_h, e.th);
                    chk("disp_hdmi", {15'd0, disp_h}, {15'd0, e.dp});
                    chk("tmds_dvi", tmds_d, e.td);
                    chk("disp_dvi", {15'd0, disp_d}, {15'd0, e.dp});
                end else if (sb[0].due < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missed_slot due=%0d now=%0d", sb[0].due, cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog cyc=%0d limit_ns=400000", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [23:0] rd;
        int          guard;
        reset = 1'b1;
        mode  = 3'd0;
        data  = '0;
        ctrl  = '0;
        aux   = '0;
        for (int l = 0; l < 3; l++) cnt_m[l] = 0;

        // T1: reset, then control with ctrl=01 on all lanes
        drive(1'b1, 3'd0, 24'd0, 6'd0, 12'd0);
        drive(1'b1, 3'd0, 24'd0, 6'd0, 12'd0);
        repeat (6) drive(1'b0, 3'd0, 24'($urandom()), 6'b010101, 12'($urandom()));

        // T2: lane 0 data 0x00 repeated
        repeat (20) begin
            rd = 24'($urandom());
            rd[7:0] = 8'h00;
            drive(1'b0, 3'd1, rd, 6'($urandom()), 12'($urandom()));
        end

        // T3: fixed bytes then random video
        drive(1'b0, 3'd1, 24'hFFFFFF, 6'd0, 12'd0);
        drive(1'b0, 3'd1, 24'h555555, 6'd0, 12'd0);
        drive(1'b0, 3'd1, 24'hAAAAAA, 6'd0, 12'd0);
        repeat (1000) drive(1'b0, 3'd1, 24'($urandom()), 6'($urandom()), 12'($urandom()));

        // T4: control, two guard symbols, then video restarting from zero disparity
        drive(1'b0, 3'd0, 24'($urandom()), 6'($urandom()), 12'($urandom()));
        drive(1'b0, 3'd2, 24'($urandom()), 6'($urandom()), 12'($urandom()));
        drive(1'b0, 3'd2, 24'($urandom()), 6'($urandom()), 12'($urandom()));
        repeat (8) drive(1'b0, 3'd1, 24'($urandom()), 6'($urandom()), 12'($urandom()));

        // T5: TERC4 sweep and island guard
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 3'd4, 24'($urandom()), 6'($urandom()), {3{4'(k)}});
        end
        rd = 24'($urandom());
        drive(1'b0, 3'd3, rd, 6'($urandom()), {rd[7:0], 4'hC});

        // T6: ctrl=11 in TERC4 mode, mixed random modes, then reset during video
        drive(1'b0, 3'd4, 24'($urandom()), 6'b111111, 12'($urandom()));
        repeat (300) drive(1'b0, 3'($urandom_range(0, 7)), 24'($urandom()), 6'($urandom()), 12'($urandom()));
        repeat (20) drive(1'b0, 3'd1, 24'($urandom()), 6'($urandom()), 12'($urandom()));
        drive(1'b1, 3'd1, 24'($urandom()), 6'($urandom()), 12'($urandom()));
        repeat (6) drive(1'b0, 3'd0, 24'($urandom()), 6'b000000, 12'($urandom()));
        repeat (10) drive(1'b0, 3'd1, 24'($urandom()), 6'($urandom()), 12'($urandom()));

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(negedge clock);
            #1;
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
